// File: rtl/register_bank.sv
// Register bank with two combinational read ports and a staged write path:
// a write is captured into a stage register and lands in the array one edge later.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  wb_pending
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  stage_valid_q, stage_valid_d;
    logic [ADDR_WIDTH-1:0] stage_addr_q,  stage_addr_d;
    logic [DATA_WIDTH-1:0] stage_data_q,  stage_data_d;

    logic write_accept;

    // Index 0 is hardwired to zero, so writes to it are dropped before the stage.
    assign write_accept = reg_write && (write_reg != '0);

    always_comb begin
        stage_valid_d = write_accept;
        stage_addr_d  = stage_addr_q;
        stage_data_d  = stage_data_q;
        if (write_accept) begin
            stage_addr_d = write_reg;
            stage_data_d = data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_data_q  <= stage_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (stage_valid_q) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (stage_addr_q == ADDR_WIDTH'(i)) begin
                    regs_q[i] <= stage_data_q;
                end
            end
        end
    end

    // Read priority: live write input, then pending stage, then committed array.
    function automatic logic [DATA_WIDTH-1:0] resolve_read(
        input logic                  in_rst,
        input logic [ADDR_WIDTH-1:0] idx,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic                  sv,
        input logic [ADDR_WIDTH-1:0] sa,
        input logic [DATA_WIDTH-1:0] sd,
        input logic [DATA_WIDTH-1:0] arr_val
    );
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (!in_rst && idx != '0) begin
            if (we && waddr == idx) begin
                val = wdata;
            end else if (sv && sa == idx) begin
                val = sd;
            end else begin
                val = arr_val;
            end
        end
        return val;
    endfunction

    logic [1:0][ADDR_WIDTH-1:0] rd_idx;
    logic [1:0][DATA_WIDTH-1:0] rd_val;

    assign rd_idx[0] = read_reg_1;
    assign rd_idx[1] = read_reg_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            assign rd_val[gi] = resolve_read(rst, rd_idx[gi], reg_write, write_reg, data_write,
                                             stage_valid_q, stage_addr_q, stage_data_q,
                                             regs_q[rd_idx[gi]]);
        end
    endgenerate

    assign read_data_1 = rd_val[0];
    assign read_data_2 = rd_val[1];
    assign wb_pending  = stage_valid_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed and randomized checks of the staged-write register bank, including
// forwarding priority, register zero, and reset discarding pending writes.
module tb_register_bank;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] data_write;
    logic [AW-1:0] read_reg_1;
    logic [AW-1:0] read_reg_2;
    logic [DW-1:0] read_data_1;
    logic [DW-1:0] read_data_2;
    logic          wb_pending;

    int checks   = 0;
    int failures = 0;

    register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .data_write (data_write),
        .read_reg_1 (read_reg_1),
        .read_reg_2 (read_reg_2),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2),
        .wb_pending (wb_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        rst = r; reg_write = we; write_reg = wa; data_write = wd;
        read_reg_1 = r1; read_reg_2 = r2;
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5);
        checks++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_read_during_rst: rd1=%h rd2=%h expected 0", read_data_1, read_data_2);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        checks++;
        if (wb_pending !== 1'b0 || read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: wbp=%b rd1=%h rd2=%h expected 0/0/0", wb_pending, read_data_1, read_data_2);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_write;
        drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        checks++;
        if (read_data_1 !== 32'hDEAD_BEEF || read_data_2 !== 32'hDEAD_BEEF || wb_pending !== 1'b0) begin
            failures++;
            $display("FAIL r5_bypass: rd1=%h rd2=%h wbp=%b expected deadbeef/deadbeef/0", read_data_1, read_data_2, wb_pending);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
        checks++;
        if (read_data_1 !== 32'hDEAD_BEEF || read_data_2 !== 32'h0 || wb_pending !== 1'b1) begin
            failures++;
            $display("FAIL r5_stage: rd1=%h rd2=%h wbp=%b expected deadbeef/0/1", read_data_1, read_data_2, wb_pending);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd5);
        checks++;
        if (read_data_2 !== 32'hDEAD_BEEF || read_data_1 !== 32'h0 || wb_pending !== 1'b0) begin
            failures++;
            $display("FAIL r5_array: rd1=%h rd2=%h wbp=%b expected 0/deadbeef/0", read_data_1, read_data_2, wb_pending);
        end
        $display("test_basic_write done");
    endtask

    task automatic test_reg_zero;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, (c < 2), 5'd0, 32'h1234_5678, 5'd0, 5'd0);
            checks++;
            if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0 || wb_pending !== 1'b0) begin
                failures++;
                $display("FAIL r0_cycle%0d: rd1=%h rd2=%h wbp=%b expected 0/0/0", c, read_data_1, read_data_2, wb_pending);
            end
        end
        $display("test_reg_zero done");
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_v [4];
        logic          exp_p [4];
        exp_v[0] = 32'h0040_0010; exp_p[0] = 1'b0;
        exp_v[1] = 32'h0040_0020; exp_p[1] = 1'b1;
        exp_v[2] = 32'h0040_0020; exp_p[2] = 1'b1;
        exp_v[3] = 32'h0040_0020; exp_p[3] = 1'b0;
        drive(1'b0, 1'b1, 5'd31, 32'h0040_0010, 5'd31, 5'd31);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) drive(1'b0, 1'b1, 5'd31, 32'h0040_0020, 5'd31, 5'd31);
            if (c >= 2) drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
            checks++;
            if (read_data_1 !== exp_v[c] || read_data_2 !== exp_v[c] || wb_pending !== exp_p[c]) begin
                failures++;
                $display("FAIL r31_b2b_cycle%0d: rd1=%h rd2=%h wbp=%b expected %h/%h/%b",
                         c, read_data_1, read_data_2, wb_pending, exp_v[c], exp_v[c], exp_p[c]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_input_beats_stage;
        drive(1'b0, 1'b1, 5'd3, 32'h22, 5'd3, 5'd5);
        drive(1'b0, 1'b1, 5'd3, 32'h11, 5'd3, 5'd5);
        checks++;
        if (read_data_1 !== 32'h11 || read_data_2 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL r3_input_over_stage: rd1=%h rd2=%h expected 11/deadbeef", read_data_1, read_data_2);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        checks++;
        if (read_data_1 !== 32'h11 || read_data_2 !== 32'h11) begin
            failures++;
            $display("FAIL r3_stage: rd1=%h rd2=%h expected 11/11", read_data_1, read_data_2);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        checks++;
        if (read_data_1 !== 32'h11 || read_data_2 !== 32'h11) begin
            failures++;
            $display("FAIL r3_array: rd1=%h rd2=%h expected 11/11", read_data_1, read_data_2);
        end
        $display("test_input_beats_stage done");
    endtask

    task automatic test_reset_discard;
        drive(1'b0, 1'b1, 5'd7, 32'hAAAA_0000, 5'd7, 5'd7);
        checks++;
        if (read_data_1 !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL r7_bypass: rd1=%h expected aaaa0000", read_data_1);
        end
        drive(1'b1, 1'b1, 5'd7, 32'h0000_0055, 5'd7, 5'd3);
        checks++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0 || wb_pending !== 1'b1) begin
            failures++;
            $display("FAIL r7_during_rst: rd1=%h rd2=%h wbp=%b expected 0/0/1", read_data_1, read_data_2, wb_pending);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
            checks++;
            if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0 || wb_pending !== 1'b0) begin
                failures++;
                $display("FAIL r7_after_rst%0d: rd1=%h rd2=%h wbp=%b expected 0/0/0", c, read_data_1, read_data_2, wb_pending);
            end
        end
        $display("test_reset_discard done");
    endtask

    task automatic test_random_stream;
        logic [DW-1:0] ref_arr [32];
        logic          st_v;
        logic [AW-1:0] st_a;
        logic [DW-1:0] st_d;
        logic [DW-1:0] e1, e2;
        logic          r, we;
        logic [AW-1:0] wa, a1, a2;
        logic [DW-1:0] wd;
        int            errs;
        // Bank is freshly reset by the previous test.
        for (int i = 0; i < 32; i++) ref_arr[i] = '0;
        st_v = 1'b0; st_a = '0; st_d = '0;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 2) != 0);
            wa = AW'($urandom_range(0, 7));
            wd = DW'($urandom);
            a1 = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 1) == 0) ? st_a : AW'($urandom_range(0, 7));
            drive(r, we, wa, wd, a1, a2);
            e1 = '0; e2 = '0;
            if (!r && a1 != 0) e1 = (we && wa == a1) ? wd : ((st_v && st_a == a1) ? st_d : ref_arr[a1]);
            if (!r && a2 != 0) e2 = (we && wa == a2) ? wd : ((st_v && st_a == a2) ? st_d : ref_arr[a2]);
            checks++;
            if (read_data_1 !== e1 || read_data_2 !== e2 || wb_pending !== st_v) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: rd1=%h rd2=%h wbp=%b expected %h/%h/%b",
                             c, read_data_1, read_data_2, wb_pending, e1, e2, st_v);
            end
            if (r) begin
                for (int i = 0; i < 32; i++) ref_arr[i] = '0;
                st_v = 1'b0; st_a = '0; st_d = '0;
            end else begin
                if (st_v) ref_arr[st_a] = st_d;
                if (we && wa != 0) begin
                    st_v = 1'b1; st_a = wa; st_d = wd;
                end else begin
                    st_v = 1'b0;
                end
            end
        end
        $display("test_random_stream done errors=%0d", errs);
    endtask

    initial begin
        rst = 1'b1; reg_write = 1'b0; write_reg = '0; data_write = '0;
        read_reg_1 = '0; read_reg_2 = '0;
        test_reset();
        test_basic_write();
        test_reg_zero();
        test_back_to_back();
        test_input_beats_stage();
        test_reset_discard();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
